// File: rtl/wb_arbiter2.sv
// Two-master to one-slave Wishbone B4 pipelined arbiter.
// Round-robin ownership per cyc burst; outstanding counter keeps responses with the issuing master.
module wb_arbiter2 #(
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  // master 0 (instruction bus)
  input  logic                   i_m0_cyc,
  input  logic                   i_m0_stb,
  input  logic                   i_m0_we,
  input  logic [DataWidth/8-1:0] i_m0_sel,
  input  logic [AddrWidth-1:0]   i_m0_adr,
  input  logic [DataWidth-1:0]   i_m0_dat_m,
  output logic [DataWidth-1:0]   o_m0_dat_s,
  output logic                   o_m0_ack,
  output logic                   o_m0_err,
  output logic                   o_m0_stall,
  // master 1 (data bus)
  input  logic                   i_m1_cyc,
  input  logic                   i_m1_stb,
  input  logic                   i_m1_we,
  input  logic [DataWidth/8-1:0] i_m1_sel,
  input  logic [AddrWidth-1:0]   i_m1_adr,
  input  logic [DataWidth-1:0]   i_m1_dat_m,
  output logic [DataWidth-1:0]   o_m1_dat_s,
  output logic                   o_m1_ack,
  output logic                   o_m1_err,
  output logic                   o_m1_stall,
  // shared slave bus
  output logic                   o_s_cyc,
  output logic                   o_s_stb,
  output logic                   o_s_we,
  output logic [DataWidth/8-1:0] o_s_sel,
  output logic [AddrWidth-1:0]   o_s_adr,
  output logic [DataWidth-1:0]   o_s_dat_m,
  input  logic [DataWidth-1:0]   i_s_dat_s,
  input  logic                   i_s_ack,
  input  logic                   i_s_err,
  input  logic                   i_s_stall
);

  localparam int unsigned CntWidth = 4;
  localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(MaxOutstanding);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t              r_state;
  logic                r_prio;
  logic [CntWidth-1:0] r_cnt;

  logic w_gnt0;
  logic w_gnt1;
  logic w_room;
  logic w_full;
  logic w_accept;
  logic w_resp;

  assign w_gnt0   = (r_state == GNT0);
  assign w_gnt1   = (r_state == GNT1);
  assign w_room   = (r_cnt < MaxCnt);
  assign w_full   = (r_cnt == MaxCnt);
  assign w_accept = o_s_stb & ~i_s_stall;
  // Responses with nothing outstanding are forwarded but never decrement.
  assign w_resp   = (i_s_ack | i_s_err) & (r_cnt != '0) & (w_gnt0 | w_gnt1);

  // Ownership FSM, favoured-master bit and outstanding-transfer counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_prio  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (i_m0_cyc && i_m1_cyc) r_state <= r_prio ? GNT1 : GNT0;
          else if (i_m0_cyc)        r_state <= GNT0;
          else if (i_m1_cyc)        r_state <= GNT1;
        end
        GNT0, GNT1: begin
          if ((w_gnt0 && !i_m0_cyc) || (w_gnt1 && !i_m1_cyc)) begin
            // Release (or abort): late responses are dropped in IDLE.
            r_state <= IDLE;
            r_prio  <= w_gnt0;
            r_cnt   <= '0;
          end else begin
            case ({w_accept, w_resp})
              2'b10:   r_cnt <= r_cnt + CntWidth'(1);
              2'b01:   r_cnt <= r_cnt - CntWidth'(1);
              default: r_cnt <= r_cnt;
            endcase
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Zero-latency routing of the owner's request and the slave's response.
  always_comb begin
    o_s_cyc    = 1'b0;
    o_s_stb    = 1'b0;
    o_s_we     = 1'b0;
    o_s_sel    = '0;
    o_s_adr    = '0;
    o_s_dat_m  = '0;
    o_m0_dat_s = '0;
    o_m0_ack   = 1'b0;
    o_m0_err   = 1'b0;
    o_m0_stall = 1'b1;
    o_m1_dat_s = '0;
    o_m1_ack   = 1'b0;
    o_m1_err   = 1'b0;
    o_m1_stall = 1'b1;
    if (w_gnt0) begin
      o_s_cyc    = i_m0_cyc;
      o_s_stb    = i_m0_stb & w_room;
      o_s_we     = i_m0_we;
      o_s_sel    = i_m0_sel;
      o_s_adr    = i_m0_adr;
      o_s_dat_m  = i_m0_dat_m;
      o_m0_dat_s = i_s_dat_s;
      o_m0_ack   = i_s_ack;
      o_m0_err   = i_s_err;
      o_m0_stall = i_s_stall | w_full;
    end else if (w_gnt1) begin
      o_s_cyc    = i_m1_cyc;
      o_s_stb    = i_m1_stb & w_room;
      o_s_we     = i_m1_we;
      o_s_sel    = i_m1_sel;
      o_s_adr    = i_m1_adr;
      o_s_dat_m  = i_m1_dat_m;
      o_m1_dat_s = i_s_dat_s;
      o_m1_ack   = i_s_ack;
      o_m1_err   = i_s_err;
      o_m1_stall = i_s_stall | w_full;
    end
  end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed self-checking bench for wb_arbiter2 (MaxOutstanding = 4).
module tb_wb_arbiter2;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_cyc, m0_stb, m0_we;
  logic [3:0]  m0_sel;
  logic [31:0] m0_adr, m0_dat_m, m0_dat_s;
  logic        m0_ack, m0_err, m0_stall;
  logic        m1_cyc, m1_stb, m1_we;
  logic [3:0]  m1_sel;
  logic [31:0] m1_adr, m1_dat_m, m1_dat_s;
  logic        m1_ack, m1_err, m1_stall;
  logic        s_cyc, s_stb, s_we;
  logic [3:0]  s_sel;
  logic [31:0] s_adr, s_dat_m, s_dat_s;
  logic        s_ack, s_err, s_stall;

  int passed = 0;
  int total  = 0;

  wb_arbiter2 #(.MaxOutstanding(4), .AddrWidth(32), .DataWidth(32)) dut (
    .clk(clk), .rst(rst),
    .i_m0_cyc(m0_cyc), .i_m0_stb(m0_stb), .i_m0_we(m0_we), .i_m0_sel(m0_sel),
    .i_m0_adr(m0_adr), .i_m0_dat_m(m0_dat_m), .o_m0_dat_s(m0_dat_s),
    .o_m0_ack(m0_ack), .o_m0_err(m0_err), .o_m0_stall(m0_stall),
    .i_m1_cyc(m1_cyc), .i_m1_stb(m1_stb), .i_m1_we(m1_we), .i_m1_sel(m1_sel),
    .i_m1_adr(m1_adr), .i_m1_dat_m(m1_dat_m), .o_m1_dat_s(m1_dat_s),
    .o_m1_ack(m1_ack), .o_m1_err(m1_err), .o_m1_stall(m1_stall),
    .o_s_cyc(s_cyc), .o_s_stb(s_stb), .o_s_we(s_we), .o_s_sel(s_sel),
    .o_s_adr(s_adr), .o_s_dat_m(s_dat_m), .i_s_dat_s(s_dat_s),
    .i_s_ack(s_ack), .i_s_err(s_err), .i_s_stall(s_stall)
  );

  always #5 clk = ~clk;

  // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_sel = 4'hF; m0_adr = '0; m0_dat_m = '0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_sel = 4'hF; m1_adr = '0; m1_dat_m = '0;
    s_dat_s = '0; s_ack = 0; s_err = 0; s_stall = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    #1;
    total++; if (s_cyc !== 1'b0) $display("FAIL reset_s_cyc got %b exp 0", s_cyc); else passed++;
    total++; if (s_adr !== 32'h0) $display("FAIL reset_s_adr got %h exp 0", s_adr); else passed++;
    total++; if ({m0_stall, m1_stall} !== 2'b11) $display("FAIL reset_stall got %b exp 11", {m0_stall, m1_stall}); else passed++;
    total++; if ({m0_ack, m0_err, m1_ack, m1_err} !== 4'b0) $display("FAIL reset_ack_err got %b exp 0000", {m0_ack, m0_err, m1_ack, m1_err}); else passed++;
    total++; if (dut.r_cnt !== 4'd0) $display("FAIL reset_cnt got %0d exp 0", dut.r_cnt); else passed++;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_single_master();
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'h100;
    #1;
    total++; if (s_cyc !== 1'b0 || m1_stall !== 1'b1) $display("FAIL single_idle got cyc=%b stall=%b exp 0/1", s_cyc, m1_stall); else passed++;
    step();
    total++; if (s_stb !== 1'b1 || s_adr !== 32'h100) $display("FAIL single_first got stb=%b adr=%h exp 1/100", s_stb, s_adr); else passed++;
    step();
    m1_adr = 32'h104;
    #1;
    total++; if (s_adr !== 32'h104 || dut.r_cnt !== 4'd1) $display("FAIL single_second got adr=%h cnt=%0d exp 104/1", s_adr, dut.r_cnt); else passed++;
    step();
    m1_adr = 32'h108; s_ack = 1; s_dat_s = 32'hAAAA_0001;
    #1;
    total++; if (m1_ack !== 1'b1 || m1_dat_s !== 32'hAAAA_0001) $display("FAIL single_ack1 got ack=%b dat=%h exp 1/aaaa0001", m1_ack, m1_dat_s); else passed++;
    total++; if (m0_ack !== 1'b0 || m0_dat_s !== 32'h0) $display("FAIL single_m0_quiet got ack=%b dat=%h exp 0/0", m0_ack, m0_dat_s); else passed++;
    step();
    // Accept and ack in the same cycle at cnt=2: no change.
    total++; if (dut.r_cnt !== 4'd2) $display("FAIL single_accept_ack_cnt got %0d exp 2", dut.r_cnt); else passed++;
    m1_stb = 0; s_dat_s = 32'hAAAA_0002;
    #1;
    total++; if (m1_ack !== 1'b1 || m1_dat_s !== 32'hAAAA_0002) $display("FAIL single_ack2 got ack=%b dat=%h exp 1/aaaa0002", m1_ack, m1_dat_s); else passed++;
    step();
    s_dat_s = 32'hAAAA_0003;
    #1;
    total++; if (m1_dat_s !== 32'hAAAA_0003 || dut.r_cnt !== 4'd1) $display("FAIL single_ack3 got dat=%h cnt=%0d exp aaaa0003/1", m1_dat_s, dut.r_cnt); else passed++;
    step();
    s_ack = 0; m1_cyc = 0;
    #1;
    total++; if (dut.r_cnt !== 4'd0 || s_cyc !== 1'b0) $display("FAIL single_end got cnt=%0d cyc=%b exp 0/0", dut.r_cnt, s_cyc); else passed++;
    step();
  endtask

  task automatic test_contention();
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'hA0;
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'hB0;
    step();
    total++; if (s_adr !== 32'hA0 || m0_stall !== 1'b0 || m1_stall !== 1'b1) $display("FAIL cont_gnt0 got adr=%h st0=%b st1=%b exp a0/0/1", s_adr, m0_stall, m1_stall); else passed++;
    step();
    m0_stb = 0; s_ack = 1; s_dat_s = 32'h1234_5678;
    #1;
    total++; if (m0_ack !== 1'b1 || m1_ack !== 1'b0 || m1_dat_s !== 32'h0) $display("FAIL cont_route got a0=%b a1=%b d1=%h exp 1/0/0", m0_ack, m1_ack, m1_dat_s); else passed++;
    step();
    s_ack = 0; m0_cyc = 0;
    step();
    total++; if (s_cyc !== 1'b0 || m1_stall !== 1'b1) $display("FAIL cont_bubble got cyc=%b st1=%b exp 0/1", s_cyc, m1_stall); else passed++;
    s_stall = 1;
    step();
    total++; if (s_stb !== 1'b1 || s_adr !== 32'hB0 || m1_stall !== 1'b1) $display("FAIL cont_gnt1 got stb=%b adr=%h st1=%b exp 1/b0/1", s_stb, s_adr, m1_stall); else passed++;
    m1_stb = 0; m1_cyc = 0; s_stall = 0;
    step();
    m0_cyc = 1; m1_cyc = 1;
    step();
    total++; if (s_adr !== 32'hA0 || m0_stall !== 1'b0 || m1_stall !== 1'b1) $display("FAIL cont_prio0 got adr=%h st0=%b st1=%b exp a0/0/1", s_adr, m0_stall, m1_stall); else passed++;
    m0_cyc = 0; m1_cyc = 0;
    step();
  endtask

  task automatic test_limit_and_error();
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h200;
    step();
    repeat (4) step();
    total++; if (dut.r_cnt !== 4'd4 || m0_stall !== 1'b1 || s_stb !== 1'b0) $display("FAIL limit_full got cnt=%0d st=%b stb=%b exp 4/1/0", dut.r_cnt, m0_stall, s_stb); else passed++;
    step();
    total++; if (dut.r_cnt !== 4'd4) $display("FAIL limit_hold got %0d exp 4", dut.r_cnt); else passed++;
    s_ack = 1;
    step();
    s_ack = 0;
    #1;
    total++; if (s_stb !== 1'b1 || m0_stall !== 1'b0 || dut.r_cnt !== 4'd3) $display("FAIL limit_fifth got stb=%b st=%b cnt=%0d exp 1/0/3", s_stb, m0_stall, dut.r_cnt); else passed++;
    step();
    m0_stb = 0; s_ack = 1;
    repeat (4) step();
    s_ack = 0;
    #1;
    total++; if (dut.r_cnt !== 4'd0) $display("FAIL limit_drain got %0d exp 0", dut.r_cnt); else passed++;
    m0_stb = 1; m0_we = 1; m0_sel = 4'b0011; m0_dat_m = 32'hDEAD_BEEF;
    #1;
    total++; if (s_we !== 1'b1 || s_sel !== 4'b0011 || s_dat_m !== 32'hDEAD_BEEF) $display("FAIL err_write got we=%b sel=%b dat=%h exp 1/0011/deadbeef", s_we, s_sel, s_dat_m); else passed++;
    step();
    m0_stb = 0; m0_we = 0; s_err = 1;
    #1;
    total++; if (m0_err !== 1'b1 || m0_ack !== 1'b0 || m1_err !== 1'b0) $display("FAIL err_route got e0=%b a0=%b e1=%b exp 1/0/0", m0_err, m0_ack, m1_err); else passed++;
    step();
    s_err = 0;
    #1;
    total++; if (m0_err !== 1'b0 || dut.r_cnt !== 4'd0) $display("FAIL err_after got e0=%b cnt=%0d exp 0/0", m0_err, dut.r_cnt); else passed++;
    m0_cyc = 0;
    step();
  endtask

  task automatic test_abort();
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'h300;
    step();
    step();
    m1_stb = 0; m1_cyc = 0;
    #1;
    total++; if (dut.r_cnt !== 4'd1) $display("FAIL abort_pre got %0d exp 1", dut.r_cnt); else passed++;
    step();
    s_ack = 1; s_dat_s = 32'h5555_5555;
    #1;
    total++; if (dut.r_cnt !== 4'd0 || s_cyc !== 1'b0) $display("FAIL abort_idle got cnt=%0d cyc=%b exp 0/0", dut.r_cnt, s_cyc); else passed++;
    total++; if ({m0_ack, m1_ack} !== 2'b00 || m1_dat_s !== 32'h0) $display("FAIL abort_late_ack got acks=%b d1=%h exp 00/0", {m0_ack, m1_ack}, m1_dat_s); else passed++;
    step();
    s_ack = 0;
    #1;
    total++; if (dut.r_cnt !== 4'd0) $display("FAIL abort_cnt got %0d exp 0", dut.r_cnt); else passed++;
  endtask

  task automatic test_reset_mid();
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'h400;
    step(); step(); step();
    total++; if (dut.r_cnt !== 4'd2 || s_cyc !== 1'b1) $display("FAIL rmid_pre got cnt=%0d cyc=%b exp 2/1", dut.r_cnt, s_cyc); else passed++;
    rst = 1;
    #1;
    total++; if (s_cyc !== 1'b0 || {m0_stall, m1_stall} !== 2'b11) $display("FAIL rmid_async got cyc=%b stalls=%b exp 0/11", s_cyc, {m0_stall, m1_stall}); else passed++;
    step();
    rst = 0;
    clear_inputs();
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'hC0;
    #1;
    total++; if (s_cyc !== 1'b0 || dut.r_cnt !== 4'd0) $display("FAIL rmid_idle got cyc=%b cnt=%0d exp 0/0", s_cyc, dut.r_cnt); else passed++;
    step();
    total++; if (s_stb !== 1'b1 || s_adr !== 32'hC0) $display("FAIL rmid_regrant got stb=%b adr=%h exp 1/c0", s_stb, s_adr); else passed++;
    clear_inputs();
    step();
  endtask

  initial begin
    test_reset();
    test_single_master();
    test_contention();
    test_limit_and_error();
    test_abort();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
